// File: rtl/msp430_pkg.sv
// Shared MSP430 datapath definitions: fetch state encoding, opcode format
// constants, register indices and the source-extension addressing rule.
package msp430_pkg;

  typedef enum logic [2:0] {
    RESET,
    FETCH_OP,
    FETCH_SRC,
    FETCH_DST,
    HOLD
  } ifetch_state_t;

  localparam logic [3:0] FMT1_MIN    = 4'h4;
  localparam logic [5:0] FMT2_PREFIX = 6'b000100;
  localparam logic [2:0] JMP_PREFIX  = 3'b001;

  localparam logic [3:0] R0 = 4'd0;
  localparam logic [3:0] R2 = 4'd2;
  localparam logic [3:0] R3 = 4'd3;

  localparam logic [1:0] AS_IDX     = 2'b01;
  localparam logic [1:0] AS_IND_INC = 2'b11;

  // Indexed/absolute/symbolic modes and #imm (@PC+) carry a word; R3 is the
  // constant generator and never does.
  function automatic logic src_ext_needed(input logic [1:0] as_mode,
                                          input logic [3:0] rs);
    return ((as_mode == AS_IDX) && (rs != R3)) ||
           ((as_mode == AS_IND_INC) && (rs == R0));
  endfunction

endpackage

// File: rtl/instr_fetch_if.sv
// Fetch-stage bus bundle: memory read port, decoder handshake and redirect.
interface instr_fetch_if;
  logic        fetch_req;
  logic [15:0] fetch_addr;
  logic        fetch_ack;
  logic [15:0] fetch_data;
  logic        ir_valid;
  logic        ir_ready;
  logic [15:0] ir_word;
  logic [15:0] src_ext;
  logic [15:0] dst_ext;
  logic [1:0]  ext_cnt;
  logic [15:0] ir_pc;
  logic [15:0] next_pc;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        pc_fault;

  modport master (
    output fetch_req, fetch_addr, ir_valid, ir_word, src_ext, dst_ext,
           ext_cnt, ir_pc, next_pc, pc_fault,
    input  fetch_ack, fetch_data, ir_ready, redirect, redirect_pc
  );

  modport slave (
    input  fetch_req, fetch_addr, ir_valid, ir_word, src_ext, dst_ext,
           ext_cnt, ir_pc, next_pc, pc_fault,
    output fetch_ack, fetch_data, ir_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/ext_word_dec.sv
// Combinational count of extension words following an MSP430 opcode word.
module ext_word_dec
  import msp430_pkg::*;
(
  input  logic [15:0] opcode,
  output logic        src_need,
  output logic        dst_need,
  output logic [1:0]  ext_cnt
);

  always_comb begin
    src_need = 1'b0;
    dst_need = 1'b0;
    if (opcode[15:13] == JMP_PREFIX) begin
      src_need = 1'b0;
    end else if (opcode[15:12] >= FMT1_MIN) begin
      src_need = src_ext_needed(opcode[5:4], opcode[11:8]);
      dst_need = opcode[7];
    end else if (opcode[15:10] == FMT2_PREFIX) begin
      src_need = src_ext_needed(opcode[5:4], opcode[3:0]);
    end
    ext_cnt = {1'b0, src_need} + {1'b0, dst_need};
  end

endmodule

// File: rtl/instr_fetch.sv
// MSP430 instruction fetch: gathers opcode plus extension words into a bundle.
// Define IFETCH_ODD_PC_CHECK_EN to flag odd redirect targets on pc_fault.
module instr_fetch
  import msp430_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [15:0]        RST_VEC,
  instr_fetch_if.master      bus
);

  ifetch_state_t state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [15:0] ir_word_q, ir_word_d;
  logic [15:0] ir_pc_q, ir_pc_d;
  logic [15:0] src_ext_q, src_ext_d;
  logic [15:0] dst_ext_q, dst_ext_d;
  logic [1:0]  ext_cnt_q, ext_cnt_d;
  logic [15:0] next_pc_q, next_pc_d;
  logic        dst_need_q, dst_need_d;
  logic        dec_src, dec_dst;
  logic [1:0]  dec_cnt;
  logic [15:0] pc_plus2;

  ext_word_dec u_ext_dec (
    .opcode   (bus.fetch_data),
    .src_need (dec_src),
    .dst_need (dec_dst),
    .ext_cnt  (dec_cnt)
  );

  assign pc_plus2 = pc_q + 16'd2;

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_word_d  = ir_word_q;
    ir_pc_d    = ir_pc_q;
    src_ext_d  = src_ext_q;
    dst_ext_d  = dst_ext_q;
    ext_cnt_d  = ext_cnt_q;
    next_pc_d  = next_pc_q;
    dst_need_d = dst_need_q;
    case (state_q)
      RESET: begin
        pc_d    = RST_VEC;
        state_d = FETCH_OP;
      end
      FETCH_OP: begin
        if (bus.fetch_ack) begin
          ir_word_d  = bus.fetch_data;
          ir_pc_d    = pc_q;
          pc_d       = pc_plus2;
          src_ext_d  = '0;
          dst_ext_d  = '0;
          ext_cnt_d  = dec_cnt;
          dst_need_d = dec_dst;
          if (dec_src) begin
            state_d = FETCH_SRC;
          end else if (dec_dst) begin
            state_d = FETCH_DST;
          end else begin
            state_d   = HOLD;
            next_pc_d = pc_plus2;
          end
        end
      end
      FETCH_SRC: begin
        if (bus.fetch_ack) begin
          src_ext_d = bus.fetch_data;
          pc_d      = pc_plus2;
          if (dst_need_q) begin
            state_d = FETCH_DST;
          end else begin
            state_d   = HOLD;
            next_pc_d = pc_plus2;
          end
        end
      end
      FETCH_DST: begin
        if (bus.fetch_ack) begin
          dst_ext_d = bus.fetch_data;
          pc_d      = pc_plus2;
          state_d   = HOLD;
          next_pc_d = pc_plus2;
        end
      end
      HOLD: begin
        if (bus.ir_ready) begin
          src_ext_d = '0;
          dst_ext_d = '0;
          state_d   = FETCH_OP;
        end
      end
      default: state_d = RESET;
    endcase
    // Redirect overrides any same-cycle ack; a HOLD handshake has already been consumed.
    if (bus.redirect && (state_q != RESET)) begin
      pc_d      = bus.redirect_pc & 16'hFFFE;
      state_d   = FETCH_OP;
      src_ext_d = '0;
      dst_ext_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= RESET;
      pc_q       <= '0;
      ir_word_q  <= '0;
      ir_pc_q    <= '0;
      src_ext_q  <= '0;
      dst_ext_q  <= '0;
      ext_cnt_q  <= '0;
      next_pc_q  <= '0;
      dst_need_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_word_q  <= ir_word_d;
      ir_pc_q    <= ir_pc_d;
      src_ext_q  <= src_ext_d;
      dst_ext_q  <= dst_ext_d;
      ext_cnt_q  <= ext_cnt_d;
      next_pc_q  <= next_pc_d;
      dst_need_q <= dst_need_d;
    end
  end

`ifdef IFETCH_ODD_PC_CHECK_EN
  logic pc_fault_q, pc_fault_d;

  always_comb begin
    pc_fault_d = bus.redirect && bus.redirect_pc[0] && (state_q != RESET);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc_fault_q <= 1'b0;
    else      pc_fault_q <= pc_fault_d;
  end

  assign bus.pc_fault = pc_fault_q;
`else
  assign bus.pc_fault = 1'b0;
`endif

  assign bus.fetch_req  = (state_q == FETCH_OP) || (state_q == FETCH_SRC) ||
                          (state_q == FETCH_DST);
  assign bus.fetch_addr = {pc_q[15:1], 1'b0};
  assign bus.ir_valid   = (state_q == HOLD);
  assign bus.ir_word    = ir_word_q;
  assign bus.ir_pc      = ir_pc_q;
  assign bus.src_ext    = src_ext_q;
  assign bus.dst_ext    = dst_ext_q;
  assign bus.ext_cnt    = ext_cnt_q;
  assign bus.next_pc    = next_pc_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: word-addressed memory model with
// configurable wait states and a bundle reference model built from opcode rules.
module tb_instr_fetch;

  typedef struct packed {
    logic [15:0] word;
    logic [15:0] pc;
    logic [15:0] src;
    logic [15:0] dst;
    logic [1:0]  cnt;
    logic [15:0] npc;
  } bundle_t;

  logic        clk;
  logic        rst;
  logic [15:0] rst_vec;
  int          total;
  int          bad;
  logic [15:0] mem [0:32767];
  int          wait_cnt;
  int          wait_target;
  int          wait_sum;
  int          fixed_waits;
  bit          rand_waits;
  logic [15:0] exp_pc;

  instr_fetch_if bus();

  instr_fetch dut (
    .clk     (clk),
    .rst     (rst),
    .RST_VEC (rst_vec),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory responder: decides ack just after each falling edge so it is stable at the rising edge.
  always @(negedge clk) begin
    #1;
    if (bus.fetch_req) begin
      if (wait_cnt < wait_target) begin
        bus.fetch_ack = 1'b0;
        wait_cnt++;
        wait_sum++;
      end else begin
        bus.fetch_ack  = 1'b1;
        bus.fetch_data = mem[bus.fetch_addr[15:1]];
        wait_cnt       = 0;
        wait_target    = rand_waits ? int'($urandom_range(0, 2)) : fixed_waits;
      end
    end else begin
      bus.fetch_ack = 1'b0;
      wait_cnt      = 0;
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic void spec_needs(input logic [15:0] op, output bit s, output bit d);
    int top4, as_m, ad, rs1, rs2;
    top4 = int'(op) / 4096;
    as_m = (int'(op) / 16) % 4;
    ad   = (int'(op) / 128) % 2;
    rs1  = (int'(op) / 256) % 16;
    rs2  = int'(op) % 16;
    s = 0;
    d = 0;
    if (top4 >= 4) begin
      s = (as_m == 1 && rs1 != 3) || (as_m == 3 && rs1 == 0);
      d = (ad == 1);
    end else if (int'(op) / 1024 == 4) begin
      s = (as_m == 1 && rs2 != 3) || (as_m == 3 && rs2 == 0);
    end
  endfunction

  function automatic bundle_t expect_at(input logic [15:0] pc);
    bundle_t     b;
    bit          s, d;
    logic [15:0] a1, a2;
    b.word = mem[pc[15:1]];
    spec_needs(b.word, s, d);
    a1 = pc + 16'd2;
    a2 = pc + 16'd4;
    b.pc  = pc;
    b.src = s ? mem[a1[15:1]] : 16'h0;
    b.dst = d ? (s ? mem[a2[15:1]] : mem[a1[15:1]]) : 16'h0;
    b.cnt = 2'(int'(s) + int'(d));
    b.npc = pc + 16'(2 * (1 + int'(s) + int'(d)));
    return b;
  endfunction

  function automatic bundle_t sample_bundle();
    bundle_t b;
    b.word = bus.ir_word;
    b.pc   = bus.ir_pc;
    b.src  = bus.src_ext;
    b.dst  = bus.dst_ext;
    b.cnt  = bus.ext_cnt;
    b.npc  = bus.next_pc;
    return b;
  endfunction

  // Entered on a falling edge while the DUT is fetching an opcode; returns at the first ir_valid edge.
  task automatic fetch_one(output bundle_t obs, output int lat, output int waits);
    int w0;
    w0  = wait_sum;
    lat = 0;
    while (!bus.ir_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
    waits = wait_sum - w0;
    obs   = sample_bundle();
  endtask

  task automatic consume(input int delay);
    repeat (delay) @(negedge clk);
    bus.ir_ready = 1'b1;
    @(negedge clk);
    bus.ir_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({bus.fetch_req, bus.fetch_addr, bus.ir_valid, bus.pc_fault} !== 19'h0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl got req=%b addr=%h valid=%b fault=%b want all 0",
               bus.fetch_req, bus.fetch_addr, bus.ir_valid, bus.pc_fault);
    end
    total++;
    if (sample_bundle() !== '0) begin
      bad++;
      $display("[TB] FAIL reset_bundle got=%h want=0", sample_bundle());
    end
  endtask

  task automatic test_reset_vector();
    bundle_t obs, exp_b;
    int lat, waits;
    rst = 1'b1;
    @(negedge clk);
    total++;
    if ({bus.fetch_req, bus.fetch_addr} !== {1'b1, 16'hC000}) begin
      bad++;
      $display("[TB] FAIL reset_vec_addr got req=%b addr=%h want req=1 addr=c000",
               bus.fetch_req, bus.fetch_addr);
    end
    exp_pc = 16'hC000;
    exp_b  = expect_at(exp_pc);
    fetch_one(obs, lat, waits);
    total++;
    if (obs !== exp_b || lat != 1) begin
      bad++;
      $display("[TB] FAIL reset_vec_bundle got=%h lat=%0d want=%h lat=1", obs, lat, exp_b);
    end
    total++;
    if ({obs.cnt, obs.npc} !== {2'd0, 16'hC002}) begin
      bad++;
      $display("[TB] FAIL reset_vec_npc got cnt=%0d npc=%h want cnt=0 npc=c002", obs.cnt, obs.npc);
    end
    exp_pc = exp_b.npc;
    consume(0);
  endtask

  task automatic test_ext_words();
    bundle_t obs, exp_b;
    int lat, waits;
    for (int i = 0; i < 3; i++) begin
      exp_b = expect_at(exp_pc);
      fetch_one(obs, lat, waits);
      total++;
      if (obs !== exp_b) begin
        bad++;
        $display("[TB] FAIL ext_bundle[%0d] got=%h want=%h", i, obs, exp_b);
      end
      total++;
      if (lat != int'(exp_b.cnt) + 1) begin
        bad++;
        $display("[TB] FAIL ext_latency[%0d] got=%0d want=%0d", i, lat, int'(exp_b.cnt) + 1);
      end
      exp_pc = exp_b.npc;
      consume(0);
    end
  endtask

  task automatic test_back_pressure();
    bundle_t obs, exp_b;
    int lat, waits;
    exp_b = expect_at(exp_pc);
    fetch_one(obs, lat, waits);
    total++;
    if (obs !== exp_b) begin
      bad++;
      $display("[TB] FAIL bp_bundle got=%h want=%h", obs, exp_b);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      total++;
      if ({bus.fetch_req, bus.ir_valid, sample_bundle()} !== {1'b0, 1'b1, exp_b}) begin
        bad++;
        $display("[TB] FAIL bp_hold[%0d] got req=%b valid=%b bundle=%h want req=0 valid=1 bundle=%h",
                 i, bus.fetch_req, bus.ir_valid, sample_bundle(), exp_b);
      end
    end
    exp_pc = exp_b.npc;
    consume(0);
  endtask

  task automatic test_wait_states();
    bundle_t obs, exp_b;
    int lat, waits;
    fixed_waits = 2;
    wait_target = 2;
    for (int i = 0; i < 2; i++) begin
      exp_b = expect_at(exp_pc);
      fetch_one(obs, lat, waits);
      total++;
      if (obs !== exp_b || lat != 3 * (int'(exp_b.cnt) + 1)) begin
        bad++;
        $display("[TB] FAIL wait_latency[%0d] got=%h lat=%0d want=%h lat=%0d",
                 i, obs, lat, exp_b, 3 * (int'(exp_b.cnt) + 1));
      end
      exp_pc = exp_b.npc;
      consume(0);
    end
    fixed_waits = 0;
    wait_target = 0;
  endtask

  task automatic test_redirect();
    bundle_t obs, exp_b;
    int lat, waits;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h3000;
    @(negedge clk);
    bus.redirect = 1'b0;
    total++;
    if ({bus.fetch_req, bus.fetch_addr, bus.ir_valid} !== {1'b1, 16'h3000, 1'b0}) begin
      bad++;
      $display("[TB] FAIL redir_first got req=%b addr=%h valid=%b want 1 3000 0",
               bus.fetch_req, bus.fetch_addr, bus.ir_valid);
    end
    @(negedge clk);
    total++;
    if ({bus.fetch_req, bus.fetch_addr} !== {1'b1, 16'h3002}) begin
      bad++;
      $display("[TB] FAIL redir_src_phase got req=%b addr=%h want 1 3002", bus.fetch_req, bus.fetch_addr);
    end
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hE000;
    @(negedge clk);
    bus.redirect = 1'b0;
    total++;
    if ({bus.fetch_req, bus.fetch_addr, bus.ir_valid} !== {1'b1, 16'hE000, 1'b0}) begin
      bad++;
      $display("[TB] FAIL redir_src_ack got req=%b addr=%h valid=%b want 1 e000 0",
               bus.fetch_req, bus.fetch_addr, bus.ir_valid);
    end
    exp_pc = 16'hE000;
    exp_b  = expect_at(exp_pc);
    fetch_one(obs, lat, waits);
    total++;
    if (obs !== exp_b || lat != 1) begin
      bad++;
      $display("[TB] FAIL redir_bundle got=%h lat=%0d want=%h lat=1", obs, lat, exp_b);
    end
    exp_pc = exp_b.npc;
    consume(0);
  endtask

  task automatic test_wrap_fault();
    bundle_t obs, exp_b;
    int lat, waits;
    logic exp_fault;
`ifdef IFETCH_ODD_PC_CHECK_EN
    exp_fault = 1'b1;
`else
    exp_fault = 1'b0;
`endif
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'hFFFE;
    @(negedge clk);
    bus.redirect = 1'b0;
    total++;
    if (bus.pc_fault !== 1'b0) begin
      bad++;
      $display("[TB] FAIL even_no_fault got=%b want=0", bus.pc_fault);
    end
    exp_pc = 16'hFFFE;
    exp_b  = expect_at(exp_pc);
    fetch_one(obs, lat, waits);
    total++;
    if (obs !== exp_b || obs.npc !== 16'h0000) begin
      bad++;
      $display("[TB] FAIL wrap_npc got=%h want=%h (npc 0000)", obs, exp_b);
    end
    consume(0);
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h8001;
    @(negedge clk);
    bus.redirect = 1'b0;
    total++;
    if ({bus.pc_fault, bus.fetch_addr} !== {exp_fault, 16'h8000}) begin
      bad++;
      $display("[TB] FAIL odd_redirect got fault=%b addr=%h want fault=%b addr=8000",
               bus.pc_fault, bus.fetch_addr, exp_fault);
    end
    exp_pc = 16'h8000;
    exp_b  = expect_at(exp_pc);
    fetch_one(obs, lat, waits);
    total++;
    if (obs !== exp_b || bus.pc_fault !== 1'b0) begin
      bad++;
      $display("[TB] FAIL odd_bundle got=%h fault=%b want=%h fault=0", obs, bus.pc_fault, exp_b);
    end
    exp_pc = exp_b.npc;
    consume(0);
  endtask

  task automatic test_random();
    bundle_t obs, exp_b;
    int lat, waits;
    for (int a = 16'h1000; a < 16'h1800; a++) mem[a] = 16'($urandom);
    rand_waits      = 1'b1;
    bus.redirect    = 1'b1;
    bus.redirect_pc = 16'h2000;
    @(negedge clk);
    bus.redirect = 1'b0;
    exp_pc = 16'h2000;
    for (int i = 0; i < 40; i++) begin
      exp_b = expect_at(exp_pc);
      fetch_one(obs, lat, waits);
      total++;
      if (obs !== exp_b) begin
        bad++;
        $display("[TB] FAIL rand_bundle[%0d] got=%h want=%h", i, obs, exp_b);
      end
      total++;
      if (lat != int'(exp_b.cnt) + 1 + waits) begin
        bad++;
        $display("[TB] FAIL rand_latency[%0d] got=%0d want=%0d", i, lat, int'(exp_b.cnt) + 1 + waits);
      end
      exp_pc = exp_b.npc;
      consume(int'($urandom_range(0, 3)));
    end
    rand_waits = 1'b0;
  endtask

  task automatic test_reset_mid();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    total++;
    if ({bus.fetch_req, bus.fetch_addr, bus.ir_valid, bus.pc_fault, sample_bundle()} !== '0) begin
      bad++;
      $display("[TB] FAIL reset_mid got req=%b addr=%h valid=%b fault=%b bundle=%h want all 0",
               bus.fetch_req, bus.fetch_addr, bus.ir_valid, bus.pc_fault, sample_bundle());
    end
  endtask

  initial begin
    total           = 0;
    bad             = 0;
    wait_cnt        = 0;
    wait_target     = 0;
    wait_sum        = 0;
    fixed_waits     = 0;
    rand_waits      = 1'b0;
    rst             = 1'b0;
    rst_vec         = 16'hC000;
    bus.fetch_ack   = 1'b0;
    bus.fetch_data  = 16'h0;
    bus.ir_ready    = 1'b0;
    bus.redirect    = 1'b0;
    bus.redirect_pc = 16'h0;
    for (int a = 0; a < 32768; a++) mem[a] = 16'h4303;
    mem[16'hC002 >> 1] = 16'h4592;
    mem[16'hC004 >> 1] = 16'h0010;
    mem[16'hC006 >> 1] = 16'h0200;
    mem[16'hC008 >> 1] = 16'h4031;
    mem[16'hC00A >> 1] = 16'h0400;
    mem[16'hC00C >> 1] = 16'h3C05;
    mem[16'hC010 >> 1] = 16'h4592;
    mem[16'hC012 >> 1] = 16'h0011;
    mem[16'hC014 >> 1] = 16'h0022;
    mem[16'h3000 >> 1] = 16'h4031;
    mem[16'h3002 >> 1] = 16'h1234;

    test_reset();
    test_reset_vector();
    test_ext_words();
    test_back_pressure();
    test_wait_states();
    test_redirect();
    test_wrap_fault();
    test_random();
    test_reset_mid();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
